cp0_regs: RTL

Parametrised CP0 register file for the MIPS32 core: BadVAddr, Count, Compare, Status, Cause, EPC, PRId, Config0 and Config1. Decoded by {reg,sel} address instead of one-hot enables, with a configurable Count prescaler and a re-enabled, routable timer interrupt. Sits beside the writeback/exception stage. It takes mtc0/mfc0 and exception/eret commits, and drives the interrupt request back into the pipeline.

---
 rtl/cp0_regs_pkg.sv | 51 +++++
 rtl/cp0_timer.sv | 64 ++++++
 rtl/cp0_regs.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/cp0_regs_pkg.sv
// CP0 address map, register field positions and exception codes shared by
// the CP0 register file and its timer.
package cp0_regs_pkg;

  // {reg[4:0], sel[2:0]} decode addresses
  localparam logic [7:0] A_BADVADDR = {5'd8,  3'd0};
  localparam logic [7:0] A_COUNT    = {5'd9,  3'd0};
  localparam logic [7:0] A_COMPARE  = {5'd11, 3'd0};
  localparam logic [7:0] A_STATUS   = {5'd12, 3'd0};
  localparam logic [7:0] A_CAUSE    = {5'd13, 3'd0};
  localparam logic [7:0] A_EPC      = {5'd14, 3'd0};
  localparam logic [7:0] A_PRID     = {5'd15, 3'd0};
  localparam logic [7:0] A_CONFIG0  = {5'd16, 3'd0};
  localparam logic [7:0] A_CONFIG1  = {5'd16, 3'd1};

  localparam int ST_IE     = 0;
  localparam int ST_EXL    = 1;
  localparam int ST_IM_LO  = 8;
  localparam int ST_BEV    = 22;

  localparam int CA_EXC_LO = 2;
  localparam int CA_IP_LO  = 8;
  localparam int CA_TI     = 30;
  localparam int CA_BD     = 31;

  localparam logic [31:0] CONFIG0_VAL = 32'h8000_0003;

  typedef enum logic [4:0] {
    EXC_INT  = 5'd0,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_SYS  = 5'd8,
    EXC_BP   = 5'd9,
    EXC_RI   = 5'd10,
    EXC_OV   = 5'd12
  } exc_code_e;

  typedef struct packed {
    logic       bev;
    logic [7:0] im;
    logic       exl;
    logic       ie;
  } status_t;

  localparam status_t STATUS_RST = '{bev: 1'b1, im: 8'h00, exl: 1'b0, ie: 1'b0};

  function automatic logic is_addr_exc(input logic [4:0] code);
    return (code == EXC_ADEL) || (code == EXC_ADES);
  endfunction

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer: prescaled Count, Compare match latches TI until the
// next Compare write.
module cp0_timer
  import cp0_regs_pkg::*;
#(
  parameter int unsigned COUNT_DIV = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        count_wen,
  input  logic        compare_wen,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        ti
);

  localparam logic [3:0] DIV_LAST = 4'(COUNT_DIV - 1);

  logic [3:0]  div_cnt_q, div_cnt_d;
  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        ti_q, ti_d;
  logic        tick;

  always_comb begin
    tick      = (div_cnt_q == DIV_LAST);
    div_cnt_d = tick ? 4'd0 : div_cnt_q + 4'd1;
    count_d   = tick ? count_q + 32'd1 : count_q;
    if (count_wen) begin
      count_d   = wdata;
      div_cnt_d = 4'd0;
    end

    compare_d = compare_wen ? wdata : compare_q;

    // A Compare write acknowledges the interrupt and beats a same-cycle match.
    ti_d = ti_q;
    if (compare_wen) begin
      ti_d = 1'b0;
    end else if (count_q == compare_q) begin
      ti_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_q <= 4'd0;
      count_q   <= 32'd0;
      compare_q <= 32'hFFFF_FFFF;
      ti_q      <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      count_q   <= count_d;
      compare_q <= compare_d;
      ti_q      <= ti_d;
    end
  end

  assign count   = count_q;
  assign compare = compare_q;
  assign ti      = ti_q;

endmodule

// File: rtl/cp0_regs.sv
// MIPS32 CP0 register file: {reg,sel} decoded mtc0/mfc0, exception and eret
// commits, interrupt sampling and the timer interrupt.
module cp0_regs
  import cp0_regs_pkg::*;
#(
  parameter int unsigned COUNT_DIV   = 2,
  parameter int unsigned TIMER_EN    = 1,
  parameter int unsigned TIMER_IP    = 7,
  parameter int unsigned TLB_ENTRIES = 16,
  parameter logic [31:0] PRID        = 32'h0001_8003
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  ext_int,
  input  logic [7:0]  addr,
  input  logic        wen,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic        exc_valid,
  input  logic        exc_eret,
  input  logic [4:0]  exc_excode,
  input  logic        exc_bd,
  input  logic [31:0] exc_epc,
  input  logic [31:0] exc_badvaddr,
  output logic [31:0] status,
  output logic [31:0] cause,
  output logic [31:0] epc,
  output logic        int_req
);

  localparam logic [5:0]  TIMER_MASK  = 6'(1) << (TIMER_IP - 2);
  localparam logic [31:0] CONFIG1_VAL = {1'b0, 6'(TLB_ENTRIES - 1), 3'd1, 3'd1, 3'd3,
                                         3'd1, 3'd1, 3'd3, 7'b0};

  status_t     status_q, status_d;
  logic        bd_q, bd_d;
  logic [4:0]  excode_q, excode_d;
  logic [7:0]  ip_q, ip_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] badvaddr_q, badvaddr_d;

  logic        mtc0_we;
  logic [5:0]  ip_hw;
  logic [31:0] count_val, compare_val;
  logic        ti;

  // An exception or eret in the same cycle swallows the mtc0 completely.
  assign mtc0_we = wen && !exc_valid;

  cp0_timer #(
    .COUNT_DIV (COUNT_DIV)
  ) u_timer (
    .clk         (clk),
    .reset       (reset),
    .count_wen   (mtc0_we && (addr == A_COUNT)),
    .compare_wen (mtc0_we && (addr == A_COMPARE)),
    .wdata       (wdata),
    .count       (count_val),
    .compare     (compare_val),
    .ti          (ti)
  );

  always_comb begin
    status_d   = status_q;
    bd_d       = bd_q;
    excode_d   = excode_q;
    epc_d      = epc_q;
    badvaddr_d = badvaddr_q;

    ip_hw = ext_int;
    if ((TIMER_EN != 0) && ti) begin
      ip_hw = ip_hw | TIMER_MASK;
    end
    ip_d = {ip_hw, ip_q[1:0]};

    if (mtc0_we) begin
      unique case (addr)
        A_STATUS: begin
          status_d.bev = wdata[ST_BEV];
          status_d.im  = wdata[ST_IM_LO +: 8];
          status_d.exl = wdata[ST_EXL];
          status_d.ie  = wdata[ST_IE];
        end
        A_CAUSE:  ip_d[1:0] = wdata[CA_IP_LO +: 2];
        A_EPC:    epc_d     = wdata;
        default:  ;
      endcase
    end

    if (exc_valid) begin
      if (exc_eret) begin
        status_d.exl = 1'b0;
      end else begin
        status_d.exl = 1'b1;
        // Nested exceptions keep the original return point and cause.
        if (!status_q.exl) begin
          epc_d    = exc_epc;
          bd_d     = exc_bd;
          excode_d = exc_excode;
        end
        if (is_addr_exc(exc_excode)) begin
          badvaddr_d = exc_badvaddr;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      status_q   <= STATUS_RST;
      bd_q       <= 1'b0;
      excode_q   <= 5'd0;
      ip_q       <= 8'd0;
      epc_q      <= 32'd0;
      badvaddr_q <= 32'd0;
    end else begin
      status_q   <= status_d;
      bd_q       <= bd_d;
      excode_q   <= excode_d;
      ip_q       <= ip_d;
      epc_q      <= epc_d;
      badvaddr_q <= badvaddr_d;
    end
  end

  always_comb begin
    status                   = 32'd0;
    status[ST_BEV]           = status_q.bev;
    status[ST_IM_LO +: 8]    = status_q.im;
    status[ST_EXL]           = status_q.exl;
    status[ST_IE]            = status_q.ie;

    cause                    = 32'd0;
    cause[CA_BD]             = bd_q;
    cause[CA_TI]             = ti;
    cause[CA_IP_LO +: 8]     = ip_q;
    cause[CA_EXC_LO +: 5]    = excode_q;
  end

  assign epc     = epc_q;
  assign int_req = (|(ip_q & status_q.im)) && status_q.ie && !status_q.exl;

  always_comb begin
    rdata = 32'd0;
    unique case (addr)
      A_BADVADDR: rdata = badvaddr_q;
      A_COUNT:    rdata = count_val;
      A_COMPARE:  rdata = compare_val;
      A_STATUS:   rdata = status;
      A_CAUSE:    rdata = cause;
      A_EPC:      rdata = epc_q;
      A_PRID:     rdata = PRID;
      A_CONFIG0:  rdata = CONFIG0_VAL;
      A_CONFIG1:  rdata = CONFIG1_VAL;
      default:    rdata = 32'd0;
    endcase
  end

endmodule
